adder: RTL and testbench

Registered WIDTH-bit binary adder with carry-out and signed-overflow flags. It sums two unsigned operands modulo 2^WIDTH and presents the result one clock after capture. It is a leaf datapath block that other arithmetic blocks and accumulators in the design instantiate. The default WIDTH is 4, so `a`, `b` and `c` are 4-bit at default.

---
 rtl/adder.sv | 46 ++++
 tb/tb_adder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adder.sv
// rtl/adder.sv - registered WIDTH-bit ripple-carry adder with carry-out and signed-overflow flags
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    // Explicit full-adder chain; carry[WIDTH-1] is kept visible for the overflow flag.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c    <= sum;
                cout <= carry[WIDTH];
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - directed self-checking bench for adder
module tb_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [3:0] c;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int checks;
    int errors;

    adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .c         (c),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ec, input logic ecout,
                             input logic eovf, input logic evalid);
        check({tag, ".c"},         {28'd0, c},         {28'd0, ec});
        check({tag, ".cout"},      {31'd0, cout},      {31'd0, ecout});
        check({tag, ".ovf"},       {31'd0, ovf},       {31'd0, eovf});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, evalid});
    endtask

    // Called at a falling edge: drive operands, then return at the next falling edge
    // so the result captured on the intervening rising edge can be sampled.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tv);
        a        = ta;
        b        = tb;
        in_valid = tv;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] sa;
        logic [3:0] sb;
        logic [4:0] full;
        logic       eovf;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        a        = 4'd5;
        b        = 4'd6;
        in_valid = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;

        step(4'd1, 4'd3, 1'b1);
        check_out("basic_1p3", 4'd4, 1'b0, 1'b0, 1'b1);

        step(4'd15, 4'd1, 1'b1);
        check_out("wrap_15p1", 4'd0, 1'b1, 1'b0, 1'b1);
        step(4'd8, 4'd8, 1'b1);
        check_out("wrap_8p8", 4'd0, 1'b1, 1'b1, 1'b1);

        step(4'd7, 4'd1, 1'b1);
        check_out("ovf_7p1", 4'd8, 1'b0, 1'b1, 1'b1);
        step(4'd14, 4'd1, 1'b1);
        check_out("noovf_14p1", 4'd15, 1'b0, 1'b0, 1'b1);

        step(4'd2, 4'd2, 1'b1);
        check_out("hold_load", 4'd4, 1'b0, 1'b0, 1'b1);
        step(4'd9, 4'd2, 1'b0);
        check_out("hold_idle", 4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd9, 4'd9, 1'b0);
        check_out("hold_idle2", 4'd4, 1'b0, 1'b0, 1'b0);

        // Drop reset between edges: outputs must clear with no clock edge.
        step(4'd7, 4'd1, 1'b1);
        check_out("pre_async", 4'd8, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("async_rst_held", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        sa = 4'd0;
        sb = 4'd0;
        for (int i = 0; i < 100; i++) begin
            sa   = sa + 4'd1;
            sb   = sa + 4'd2;
            full = {1'b0, sa} + {1'b0, sb};
            eovf = (sa[3] == sb[3]) && (full[3] != sa[3]);
            step(sa, sb, 1'b1);
            check_out("sweep", full[3:0], full[4], eovf, 1'b1);
            if (sa == 4'd15) begin
                check("sweep_15p1.c",    {28'd0, c},    32'd0);
                check("sweep_15p1.cout", {31'd0, cout}, 32'd1);
            end
            if (sa == 4'd0) begin
                check("sweep_0p2.c",    {28'd0, c},    32'd2);
                check("sweep_0p2.cout", {31'd0, cout}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
